// File: rtl/transmitter_data_pkg.sv
// Shared MIL-STD-1553 word definitions and Manchester II / parity helpers.
package lib_1553;

    localparam int M1553_NUM_DATA_BITS   = 16;
    localparam int M1553_NUM_PARITY_BITS = 1;

    typedef logic [M1553_NUM_DATA_BITS-1:0] word_t;

    typedef enum logic {
        SYNC_DATA = 1'b0,
        SYNC_CMD  = 1'b1
    } sync_t;

    // Receive side: chip pair {first, second} -> {valid, bit}; 10 = 1, 01 = 0.
    function automatic logic [1:0] Decode_Manchester_Chips(input logic [1:0] chips);
        return {chips[1] ^ chips[0], chips[1]};
    endfunction

    // Transmit side: bit -> chip pair {first, second}; inverse of the decoder.
    function automatic logic [1:0] Encode_Manchester_Bit(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    // Odd parity: ones(word) + parity is always odd.
    function automatic logic Calc_Odd_Parity(input word_t w);
        return ~^w;
    endfunction

endpackage

// File: rtl/transmitter_data.sv
// Manchester II serializer for one 1553 word: sync, 16 data bits MSB first,
// odd parity. Output chips advance only on i_chip_tick.
module transmitter_data
    import lib_1553::*;
#(
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   SYNC_CHIPS = 6
) (
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_clear,
    input  logic  i_chip_tick,
    input  logic  i_start,
    input  logic  i_sync_type,
    input  word_t i_data_word,
    output logic  o_ready,
    output logic  o_busy,
    output logic  o_done,
    output logic  o_tx_out,
    output logic  o_tx_en
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [2:0] SYNC_HALF = 3'(SYNC_CHIPS / 2);
    localparam logic [2:0] SYNC_LAST = 3'(SYNC_CHIPS - 1);
    // bit_idx value that carries the parity bit
    localparam logic [4:0] PARITY_IDX = 5'(M1553_NUM_DATA_BITS);

    logic [1:0] r_state;
    word_t      r_word;
    sync_t      r_sync;
    logic       r_parity;
    logic [2:0] r_sync_cnt;
    logic [4:0] r_bit_idx;
    logic       r_chip_idx;
    logic       r_last;       // final data chip is on the line; next tick ends the frame
    logic       r_tx_out;
    logic       r_tx_en;

    logic [3:0] w_sel;
    logic       w_bit;
    logic [1:0] w_pair;
    logic       w_data_chip;
    logic       w_sync_chip;

    // Chip selection for the current sync/data position
    always_comb begin
        w_sel       = 4'd15 - r_bit_idx[3:0];
        w_bit       = (r_bit_idx == PARITY_IDX) ? r_parity : r_word[w_sel];
        w_pair      = Encode_Manchester_Bit(w_bit);
        w_data_chip = r_chip_idx ? w_pair[0] : w_pair[1];
        // Command sync is high-then-low, data sync low-then-high
        w_sync_chip = (r_sync_cnt < SYNC_HALF) ? (r_sync == SYNC_CMD) : (r_sync != SYNC_CMD);
    end

    // Frame sequencer; reset and clear abort immediately, independent of tick
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_sync     <= SYNC_DATA;
            r_parity   <= 1'b0;
            r_sync_cnt <= '0;
            r_bit_idx  <= '0;
            r_chip_idx <= 1'b0;
            r_last     <= 1'b0;
            r_tx_out   <= IDLE_LEVEL;
            r_tx_en    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A tick coinciding with accept is deliberately not used
                    if (i_start) begin
                        r_word     <= i_data_word;
                        r_sync     <= sync_t'(i_sync_type);
                        r_parity   <= Calc_Odd_Parity(i_data_word);
                        r_sync_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_chip_idx <= 1'b0;
                        r_last     <= 1'b0;
                        r_state    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (i_chip_tick) begin
                        r_tx_en  <= 1'b1;
                        r_tx_out <= w_sync_chip;
                        if (r_sync_cnt == SYNC_LAST) begin
                            r_state    <= ST_DATA;
                            r_bit_idx  <= '0;
                            r_chip_idx <= 1'b0;
                        end else begin
                            r_sync_cnt <= r_sync_cnt + 3'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_chip_tick) begin
                        if (r_last) begin
                            r_tx_en  <= 1'b0;
                            r_tx_out <= IDLE_LEVEL;
                            r_last   <= 1'b0;
                            r_state  <= ST_DONE;
                        end else begin
                            r_tx_out   <= w_data_chip;
                            r_chip_idx <= ~r_chip_idx;
                            if (r_chip_idx) begin
                                if (r_bit_idx == PARITY_IDX)
                                    r_last <= 1'b1;
                                else
                                    r_bit_idx <= r_bit_idx + 5'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_tx_en  <= 1'b0;
                    r_tx_out <= IDLE_LEVEL;
                end
            endcase
        end
    end

    assign o_ready  = (r_state == ST_IDLE);
    assign o_busy   = (r_state == ST_SYNC) || (r_state == ST_DATA);
    assign o_done   = (r_state == ST_DONE);
    assign o_tx_out = r_tx_out;
    assign o_tx_en  = r_tx_en;

endmodule

// File: tb/tb_transmitter_data.sv
// Bench for transmitter_data: directed and random frames against a
// rule-level frame model, plus clear/reset abort and decode-back checks.
module tb_transmitter_data;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_chip_tick = 1'b0;
    logic        i_start = 1'b0;
    logic        i_sync_type = 1'b0;
    logic [15:0] i_data_word = '0;
    logic        o_ready, o_busy, o_done, o_tx_out, o_tx_en;

    transmitter_data dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (i_clear),
        .i_chip_tick (i_chip_tick),
        .i_start     (i_start),
        .i_sync_type (i_sync_type),
        .i_data_word (i_data_word),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_tx_out    (o_tx_out),
        .o_tx_en     (o_tx_en)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Chip strobe: one pulse every tick_div clocks, or held high when stuck
    int tick_div = 4;
    int tick_cnt = 0;
    bit tick_stuck = 0;
    always @(negedge i_clk) begin
        if (tick_stuck) i_chip_tick = 1'b1;
        else begin
            tick_cnt++;
            if (tick_cnt >= tick_div) begin
                tick_cnt = 0;
                i_chip_tick = 1'b1;
            end else i_chip_tick = 1'b0;
        end
    end

    // Line monitor: capture one chip per used tick, count done cycles,
    // and flag any output movement without a tick/reset/clear edge
    logic tick_q, rst_q, clr_q;
    logic prev_out, prev_en;
    logic chips[$];
    int   done_cnt = 0;
    int   viol = 0;
    always @(posedge i_clk) begin
        tick_q <= i_chip_tick;
        rst_q  <= i_reset;
        clr_q  <= i_clear;
    end
    always @(negedge i_clk) begin
        if (tick_q === 1'b1 && o_tx_en === 1'b1) chips.push_back(o_tx_out);
        if (o_done === 1'b1) done_cnt++;
        if (tick_q === 1'b0 && rst_q === 1'b0 && clr_q === 1'b0 &&
            (o_tx_out !== prev_out || o_tx_en !== prev_en)) viol++;
        prev_out = o_tx_out;
        prev_en  = o_tx_en;
    end

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    // Expected 40-chip frame from the protocol rules
    function automatic logic [39:0] model_frame(input logic [15:0] w, input logic t);
        logic [39:0] f;
        logic        par;
        int          k;
        k = 39;
        for (int i = 0; i < 6; i++) begin
            f[k] = (i < 3) ? t : ~t;
            k--;
        end
        for (int i = 15; i >= 0; i--) begin
            f[k]     = w[i];
            f[k - 1] = ~w[i];
            k -= 2;
        end
        par  = ($countones(w) % 2 == 0);
        f[1] = par;
        f[0] = ~par;
        return f;
    endfunction

    function automatic logic [39:0] pack_chips();
        logic [39:0] g;
        g = '0;
        foreach (chips[i]) g = {g[38:0], chips[i]};
        return g;
    endfunction

    task automatic send_frame(input string tag, input logic [15:0] w, input logic t,
                              input bit hammer, output logic [39:0] got);
        int guard;
        int rdy_viol;
        guard = 0;
        while (!o_ready && guard < 100) begin
            step();
            guard++;
        end
        chips.delete();
        done_cnt = 0;
        rdy_viol = 0;
        i_start = 1'b1;
        i_data_word = w;
        i_sync_type = t;
        step();
        i_start = hammer;
        i_data_word = 16'($urandom);
        i_sync_type = ~t;
        guard = 0;
        while (done_cnt == 0 && guard < 45 * tick_div + 50) begin
            if (o_ready) rdy_viol++;
            if (hammer) i_data_word = 16'($urandom);
            step();
            guard++;
        end
        i_start = 1'b0;
        chk({tag, "_done_seen"}, 40'(done_cnt > 0), 40'd1);
        if (hammer) chk({tag, "_ready_low"}, 40'(rdy_viol), 40'd0);
        chk({tag, "_txen_off"}, {38'd0, o_tx_en, o_tx_out}, 40'd0);
        step();
        chk({tag, "_ready_after"}, {38'd0, o_ready, o_busy}, 40'b10);
        step();
        chk({tag, "_done_once"}, 40'(done_cnt), 40'd1);
        chk({tag, "_len"}, 40'(chips.size()), 40'd40);
        got = pack_chips();
        chk({tag, "_frame"}, got, model_frame(w, t));
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, {35'd0, o_tx_en, o_tx_out, o_done, o_busy, o_ready}, 40'b00001);
    endtask

    logic [39:0] frm;
    logic [15:0] dw;
    logic        dpar, dvalid;
    int          guard;

    initial begin
        repeat (4) step();
        chk_idle("reset_state");
        i_reset = 1'b0;
        step();
        chk_idle("post_reset");

        tick_div = 4;
        send_frame("w0000", 16'h0000, 1'b0, 0, frm);
        send_frame("wFFFF", 16'hFFFF, 1'b1, 0, frm);
        send_frame("w8001", 16'h8001, 1'b0, 0, frm);
        tick_div = 3;
        send_frame("hammer", 16'hA5C3, 1'b1, 1, frm);

        for (int n = 0; n < 6; n++) begin
            tick_div = int'($urandom_range(2, 6));
            send_frame($sformatf("rnd%0d", n), 16'($urandom), 1'($urandom),
                       bit'($urandom_range(0, 1)), frm);
        end

        // Abort with clear mid-frame
        tick_div = 4;
        chips.delete();
        done_cnt = 0;
        i_start = 1'b1;
        i_data_word = 16'h5A5A;
        i_sync_type = 1'b0;
        step();
        i_start = 1'b0;
        guard = 0;
        while (chips.size() < 20 && guard < 500) begin
            step();
            guard++;
        end
        chk("clr_reached", {39'd0, o_tx_en}, 40'd1);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        chk_idle("clr_idle");
        repeat (200) step();
        chk("clr_no_done", 40'(done_cnt), 40'd0);
        send_frame("after_clr", 16'h0F0F, 1'b1, 0, frm);

        // Reset while the tick is held high
        chips.delete();
        i_start = 1'b1;
        i_data_word = 16'hC3C3;
        step();
        i_start = 1'b0;
        guard = 0;
        while (chips.size() < 10 && guard < 500) begin
            step();
            guard++;
        end
        tick_stuck = 1;
        i_reset = 1'b1;
        step();
        chk_idle("rst_stuck");
        step();
        chk_idle("rst_stuck2");
        i_reset = 1'b0;
        tick_stuck = 0;
        step();
        chk_idle("rst_release");

        // Decode a frame back to word and parity
        send_frame("loop1234", 16'h1234, 1'b1, 0, frm);
        dvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            dw[15 - i] = frm[33 - 2 * i];
            if (frm[33 - 2 * i] == frm[32 - 2 * i]) dvalid = 1'b0;
        end
        dpar = frm[1];
        if (frm[1] == frm[0]) dvalid = 1'b0;
        chk("loop_word", 40'(dw), 40'h1234);
        chk("loop_valid", 40'(dvalid), 40'd1);
        chk("loop_parity", 40'(($countones(dw) + int'(dpar)) % 2), 40'd1);
        chk("loop_sync", 40'(frm[39:34]), 40'b111000);

        chk("tick_only_changes", 40'(viol), 40'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
